// File: rtl/trace_ctrl_if.sv
// Request, mux and word-stream signals of the trace sequencer.
// master = trace_ctrl itself, slave = request decoder / mux / consumer side.
interface trace_ctrl_if #(
  parameter int SEL_W = 9
);
  logic             req_valid;
  logic [7:0]       bRequest;
  logic [15:0]      parameter_Block16;
  logic             q;
  logic [SEL_W-1:0] actual_select;
  logic [SEL_W-1:0] select;
  logic             word_valid;
  logic             word_ready;
  logic [15:0]      word_data;
  logic [SEL_W-1:0] word_base;
  logic             busy;
  logic             err_sel;
  logic             err_cmd;

  // Stream handshake: a word transfers on a rising edge where word_valid and
  // word_ready are both high; word_valid never drops and word_data/word_base
  // never change before that edge, except when an ABORT discards the word.
  modport master (
    input  req_valid, bRequest, parameter_Block16, q, actual_select, word_ready,
    output select, word_valid, word_data, word_base, busy, err_sel, err_cmd
  );

  modport slave (
    output req_valid, bRequest, parameter_Block16, q, actual_select, word_ready,
    input  select, word_valid, word_data, word_base, busy, err_sel, err_cmd
  );
endinterface

// File: rtl/trace_ctrl.sv
// Trace mux sequencer: decodes SET/SCAN/ABORT requests, sweeps select with a
// settle delay, samples q and streams 16-sample words with their base select.
module trace_ctrl #(
  parameter int SEL_W  = 9,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           reset,
  trace_ctrl_if.master   bus,
  output logic [1:0]     o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_PUSH   = 2'd3
  } state_t;

  localparam logic [7:0] REQ_SET   = 8'h01;
  localparam logic [7:0] REQ_SCAN  = 8'h02;
  localparam logic [7:0] REQ_ABORT = 8'h03;

  // The SETTLE state holds for SETTLE cycles and SAMPLE adds one more, so the
  // counter is loaded with SETTLE-1; with SETTLE = 0 the SETTLE state is skipped.
  localparam logic [3:0] SETTLE_LD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam state_t     FIRST_ST  = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t           r_state;
  logic [SEL_W-1:0] r_select;
  logic [SEL_W-1:0] r_base;
  logic [15:0]      r_shreg;
  logic [3:0]       r_bit;
  logic [3:0]       r_settle;
  logic [7:0]       r_words;
  logic             r_word_valid;
  logic             r_busy;
  logic             r_err_sel;
  logic             r_err_cmd;

  logic             w_idle;
  logic             w_req_set;
  logic             w_req_scan;
  logic             w_req_abort;
  logic             w_set_go;
  logic             w_scan_go;
  logic             w_cmd_err;
  logic [SEL_W-1:0] w_set_value;
  logic [SEL_W-1:0] w_scan_start;
  logic [7:0]       w_scan_words;

  assign w_idle       = (r_state == S_IDLE);
  assign w_req_set    = bus.req_valid && (bus.bRequest == REQ_SET);
  assign w_req_scan   = bus.req_valid && (bus.bRequest == REQ_SCAN);
  assign w_req_abort  = bus.req_valid && (bus.bRequest == REQ_ABORT);
  assign w_set_go     = w_req_set && w_idle;
  assign w_scan_go    = w_req_scan && w_idle;
  // Anything strobed that is neither ABORT nor an accepted SET/SCAN is an error.
  assign w_cmd_err    = bus.req_valid && !w_req_abort && !w_set_go && !w_scan_go;
  assign w_set_value  = SEL_W'(bus.parameter_Block16);
  assign w_scan_start = SEL_W'(bus.parameter_Block16[8:0]);
  assign w_scan_words = 8'(bus.parameter_Block16[15:9]) + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_select     <= '0;
      r_base       <= '0;
      r_shreg      <= '0;
      r_bit        <= '0;
      r_settle     <= '0;
      r_words      <= '0;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_err_sel    <= 1'b0;
      r_err_cmd    <= 1'b0;
    end else begin
      r_err_cmd <= w_cmd_err;
      if (w_req_abort) begin
        // ABORT overrides every state, including a handshake in the same cycle.
        r_state      <= S_IDLE;
        r_busy       <= 1'b0;
        r_word_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_scan_go) begin
              r_select  <= w_scan_start;
              r_bit     <= 4'd0;
              r_words   <= w_scan_words;
              r_settle  <= SETTLE_LD;
              r_err_sel <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= FIRST_ST;
            end else if (w_set_go) begin
              r_select <= w_set_value;
            end
          end
          S_SETTLE: begin
            if (r_settle == 4'd0) begin
              r_state <= S_SAMPLE;
            end else begin
              r_settle <= r_settle - 4'd1;
            end
          end
          S_SAMPLE: begin
            r_shreg[r_bit] <= bus.q;
            if (r_bit == 4'd0) begin
              r_base <= r_select;
            end
            if (bus.actual_select != r_select) begin
              r_err_sel <= 1'b1;
            end
            r_select <= r_select + SEL_W'(1);
            if (r_bit == 4'd15) begin
              r_word_valid <= 1'b1;
              r_state      <= S_PUSH;
            end else begin
              r_bit    <= r_bit + 4'd1;
              r_settle <= SETTLE_LD;
              r_state  <= FIRST_ST;
            end
          end
          S_PUSH: begin
            if (bus.word_ready) begin
              r_word_valid <= 1'b0;
              if (r_words == 8'd1) begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_words  <= r_words - 8'd1;
                r_bit    <= 4'd0;
                r_settle <= SETTLE_LD;
                r_state  <= FIRST_ST;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.select     = r_select;
  assign bus.word_valid = r_word_valid;
  assign bus.word_data  = r_shreg;
  assign bus.word_base  = r_base;
  assign bus.busy       = r_busy;
  assign bus.err_sel    = r_err_sel;
  assign bus.err_cmd    = r_err_cmd;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_trace_ctrl.sv
// Bench for trace_ctrl: a cycle-arithmetic model of the sweep predicts every
// output each cycle; directed scenarios add hand-computed literal expectations.
module tb_trace_ctrl;
  localparam int SEL_W = 9;
  localparam int P     = 2;   // SETTLE + 1 cycles per sample
  localparam int WW    = SEL_W + 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;
  int         q_mode = 0;
  logic       bad_echo = 1'b0;

  trace_ctrl_if #(.SEL_W(SEL_W)) bus ();

  trace_ctrl #(.SEL_W(SEL_W), .SETTLE(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / mux stand-in ----------------
  always #5 clk = ~clk;

  function automatic logic qf(input logic [SEL_W-1:0] s, input int mode);
    if (mode == 0) return s[0];
    return s[0] ^ s[2] ^ s[5];
  endfunction

  assign bus.q             = qf(bus.select, q_mode);
  assign bus.actual_select = bad_echo ? (bus.select ^ 9'd1) : bus.select;

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int        cyc = 0;
  bit        m_busy = 0;
  bit        m_err_sel = 0;
  int        m_w = 0;
  int        m_base = 0;
  int        m_left = 0;
  int        m_sel_idle = 0;
  int        m_err_cmd_at = -10;
  logic [WW-1:0] exp_q[$];

  function automatic int done_n(input int c);
    int n;
    if (c < m_w) return 0;
    n = (c - m_w) / P;
    return (n > 16) ? 16 : n;
  endfunction

  function automatic logic [WW-1:0] make_word(input int base);
    logic [15:0] d;
    for (int k = 0; k < 16; k++) d[k] = qf(SEL_W'((base + k) & 511), q_mode);
    return {SEL_W'(base & 511), d};
  endfunction

  always @(posedge clk) begin
    bit was_busy;
    bit is_abort;
    int t;
    cyc++;
    if (reset) begin
      m_busy = 0; m_err_sel = 0; m_sel_idle = 0; m_err_cmd_at = -10;
      exp_q.delete();
    end else begin
      was_busy = m_busy;
      is_abort = bus.req_valid && (bus.bRequest == 8'h03);
      if (is_abort) begin
        if (m_busy) begin
          m_sel_idle = (m_base + done_n(cyc - 1)) & 511;
          m_busy = 0;
          exp_q.delete();
        end
      end else if (m_busy) begin
        t = cyc - m_w;
        if (t > 0 && (t % P) == 0 && (t / P) <= 16 && bad_echo) m_err_sel = 1;
        if ((cyc - 1 - m_w) >= 16 * P && bus.word_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_left--;
          if (m_left == 0) begin
            m_busy = 0;
            m_sel_idle = (m_base + 16) & 511;
          end else begin
            m_base = (m_base + 16) & 511;
            m_w = cyc;
          end
        end
      end
      if (bus.req_valid && !is_abort) begin
        if (!was_busy && bus.bRequest == 8'h01) begin
          m_sel_idle = bus.parameter_Block16 & 511;
        end else if (!was_busy && bus.bRequest == 8'h02) begin
          m_busy = 1; m_err_sel = 0; m_w = cyc;
          m_base = bus.parameter_Block16 & 511;
          m_left = (bus.parameter_Block16 >> 9) + 1;
          for (int w = 0; w < m_left; w++) exp_q.push_back(make_word(m_base + 16 * w));
        end else begin
          m_err_cmd_at = cyc;
        end
      end
    end
  end

  // ---------------- per-cycle compare + handshake capture ----------------
  logic [SEL_W-1:0] got_base[$];
  logic [15:0]      got_data[$];
  logic             prev_valid = 1'b0;
  int               rise_cyc = 0;

  always @(negedge clk) begin
    int n;
    logic [SEL_W-1:0] e_sel;
    logic e_valid;
    if (!reset) begin
      n = m_busy ? done_n(cyc) : 0;
      e_sel = m_busy ? SEL_W'((m_base + n) & 511) : SEL_W'(m_sel_idle);
      e_valid = m_busy && (n == 16);
      check("select", 32'(bus.select), 32'(e_sel));
      check("word_valid", 32'(bus.word_valid), 32'(e_valid));
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("err_sel", 32'(bus.err_sel), 32'(m_err_sel));
      check("err_cmd", 32'(bus.err_cmd), 32'(cyc == m_err_cmd_at));
      if (e_valid && bus.word_valid) begin
        if (exp_q.size() == 0) check("word_expected", 32'(1), 32'(0));
        else check("word", 32'({bus.word_base, bus.word_data}), 32'(exp_q[0]));
      end
      if (bus.word_valid && !prev_valid) rise_cyc = cyc;
      if (bus.word_valid && bus.word_ready && !(bus.req_valid && bus.bRequest == 8'h03)) begin
        got_base.push_back(bus.word_base);
        got_data.push_back(bus.word_data);
      end
      prev_valid = bus.word_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  int last_edge = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [7:0] code, input logic [15:0] param);
    bus.req_valid = 1'b1;
    bus.bRequest = code;
    bus.parameter_Block16 = param;
    tick();
    last_edge = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while (bus.busy && k < max_cyc) begin
      tick();
      k++;
    end
    check("idle_timeout", 32'(bus.busy), 32'(0));
  endtask

  task automatic wait_words(input int target, input int max_cyc);
    int k;
    k = 0;
    while (got_data.size() < target && k < max_cyc) begin
      tick();
      k++;
    end
    check("word_timeout", 32'(got_data.size()), 32'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_select"}, 32'(bus.select), 32'(0));
    check({tag, "_valid"}, 32'(bus.word_valid), 32'(0));
    check({tag, "_data"}, 32'(bus.word_data), 32'(0));
    check({tag, "_base"}, 32'(bus.word_base), 32'(0));
    check({tag, "_busy"}, 32'(bus.busy), 32'(0));
    check({tag, "_err_sel"}, 32'(bus.err_sel), 32'(0));
    check({tag, "_err_cmd"}, 32'(bus.err_cmd), 32'(0));
    check({tag, "_state"}, 32'(dbg_state), 32'(0));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int g0;
    int k;
    bus.req_valid = 1'b0;
    bus.bRequest = 8'h00;
    bus.parameter_Block16 = 16'h0000;
    bus.word_ready = 1'b1;

    #1;
    check_all_zero("reset");
    tick(); tick();
    reset = 1'b0;
    tick();

    // SET: one-cycle latency, no scan.
    send_req(8'h01, 16'h00A5);
    check("set_select", 32'(bus.select), 32'h0A5);
    check("set_busy", 32'(bus.busy), 32'(0));
    tick(); tick();
    check("set_no_valid", 32'(bus.word_valid), 32'(0));

    // Single word, q follows select[0].
    q_mode = 0;
    send_req(8'h02, 16'h0000);
    g0 = last_edge;
    wait_idle(200);
    check("w1_count", 32'(got_data.size()), 32'(1));
    check("w1_data", 32'(got_data[0]), 32'hAAAA);
    check("w1_base", 32'(got_base[0]), 32'h000);
    check("w1_rise", 32'(rise_cyc - g0), 32'(32));
    check("w1_err_sel", 32'(bus.err_sel), 32'(0));

    // Three words across the 511 -> 0 wrap, stall on word 2.
    q_mode = 1;
    g0 = got_data.size();
    send_req(8'h02, 16'h05F8);
    wait_words(g0 + 1, 200);
    bus.word_ready = 1'b0;
    k = 0;
    while (!bus.word_valid && k < 200) begin
      tick();
      k++;
    end
    check("stall_valid_seen", 32'(bus.word_valid), 32'(1));
    repeat (10) tick();
    bus.word_ready = 1'b1;
    wait_idle(300);
    check("w3_count", 32'(got_data.size() - g0), 32'(3));
    check("w3_base0", 32'(got_base[g0]), 32'h1F8);
    check("w3_base1", 32'(got_base[g0 + 1]), 32'h008);
    check("w3_base2", 32'(got_base[g0 + 2]), 32'h018);
    check("w3_err_sel", 32'(bus.err_sel), 32'(0));

    // ABORT coincident with the word-2 handshake: word 2 is dropped.
    q_mode = 0;
    g0 = got_data.size();
    send_req(8'h02, 16'h0610);
    wait_words(g0 + 1, 200);
    k = 0;
    while (!bus.word_valid && k < 200) begin
      tick();
      k++;
    end
    check("abort_valid_seen", 32'(bus.word_valid), 32'(1));
    send_req(8'h03, 16'h0000);
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_valid", 32'(bus.word_valid), 32'(0));
    check("abort_state", 32'(dbg_state), 32'(0));
    check("abort_select", 32'(bus.select), 32'h030);
    repeat (80) tick();
    check("abort_words", 32'(got_data.size() - g0), 32'(1));

    // Illegal requests during a scan, plus one corrupted echo.
    send_req(8'h02, 16'h0240);
    repeat (3) tick();
    send_req(8'h01, 16'h0123);
    check("set_busy_err", 32'(bus.err_cmd), 32'(1));
    tick();
    check("set_busy_err_end", 32'(bus.err_cmd), 32'(0));
    send_req(8'h7F, 16'h0000);
    check("unknown_err", 32'(bus.err_cmd), 32'(1));
    tick();
    check("unknown_err_end", 32'(bus.err_cmd), 32'(0));
    bad_echo = 1'b1;
    tick(); tick();
    bad_echo = 1'b0;
    wait_idle(300);
    check("sticky_err_sel", 32'(bus.err_sel), 32'(1));
    check("scan5_last_base", 32'(got_base[got_base.size() - 1]), 32'h050);
    repeat (5) tick();
    check("sticky_err_sel_hold", 32'(bus.err_sel), 32'(1));

    // Asynchronous reset in a SETTLE cycle.
    g0 = got_data.size();
    send_req(8'h02, 16'h0000);
    check("scan_clears_err_sel", 32'(bus.err_sel), 32'(0));
    repeat (4) tick();
    check("pre_reset_state", 32'(dbg_state), 32'(1));
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick(); tick();
    reset = 1'b0;
    repeat (40) tick();
    check("post_reset_words", 32'(got_data.size() - g0), 32'(0));
    send_req(8'h02, 16'h0000);
    wait_idle(200);
    check("post_reset_count", 32'(got_data.size() - g0), 32'(1));
    check("post_reset_data", 32'(got_data[got_data.size() - 1]), 32'hAAAA);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trace_ctrl.md
# trace_ctrl

Sequencer for the trace multiplexer. It decodes 8-bit trace requests (`bRequest` plus a 16-bit `parameter_Block16`), drives the mux `select`, waits a settle time, samples the 1-bit `q`, and packs 16 samples per word onto a valid/ready output stream. It sits between the request decoder and the trace mux/capture path. It replaces manual stepping of `select` with a hardware sweep that can be aborted.

## Interface
Parameters:
- `SEL_W`, default 9: select width; the sweep wraps modulo 2^SEL_W.
- `SETTLE`, default 1, legal range 0..15: idle cycles between a `select` change and its sample.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `req_valid`, in, 1: single-cycle request strobe.
- `bRequest`, in, 8: request code; sampled only when `req_valid` is high.
- `parameter_Block16`, in, 16: request argument; sampled only when `req_valid` is high.
- `q`, in, 1: mux output bit.
- `actual_select`, in, SEL_W: select value echoed back by the mux.
- `select`, out, SEL_W: drives the mux.
- `word_valid`, out, 1: packed word available.
- `word_ready`, in, 1: consumer accepts the word.
- `word_data`, out, 16: packed samples, LSB = first sample.
- `word_base`, out, SEL_W: select value of `word_data[0]`.
- `busy`, out, 1: a scan is in progress.
- `err_sel`, out, 1: sticky flag; set when `actual_select` != `select` at any sample.
- `err_cmd`, out, 1: one-cycle pulse on an unknown or illegal request.

## Operation
- Request codes:
  - **0x01 SET**: `select` <= `parameter_Block16[SEL_W-1:0]`. No words are produced. Legal only when idle.
  - **0x02 SCAN**: start = `parameter_Block16[8:0]`; word count N = `parameter_Block16[15:9]` + 1 (1..128). Clears `err_sel`. Legal only when idle.
  - **0x03 ABORT**: legal in any state; always returns to IDLE.
  - Any other code: pulse `err_cmd`, no state change.
- SET or SCAN received while `busy`: pulse `err_cmd`, request ignored.
- FSM states:
  - **IDLE** -> SETTLE on accepted SCAN: load `select` = start, bit index 0, word counter = N, settle counter = SETTLE.
  - **SETTLE**: decrement the settle counter. When it is 0 (or immediately if SETTLE = 0), go to SAMPLE.
  - **SAMPLE**, one cycle: write `q` into `shreg[bit]`; compare `actual_select` with `select` and set `err_sel` on mismatch; `select` <= `select` + 1 mod 2^SEL_W.
    - If bit = 15: go to PUSH.
    - Otherwise: bit++, reload the settle counter, go to SETTLE.
  - **PUSH**: `word_valid` = 1; `word_data` and `word_base` stay stable until the handshake.
    - On `word_valid && word_ready`: decrement the word counter. If it reaches 0, go to IDLE; otherwise bit = 0, reload the settle counter, go to SETTLE.
    - While stalled in PUSH, `select` holds at base + 16.
- ABORT: takes effect on the edge it is sampled. `word_valid` drops and any partial or pending word is discarded. `select` keeps its current value. `err_sel` is kept.
- `busy` = (state != IDLE).
- Reset value of every output is 0.

## Timing
- SCAN accepted at edge E0: sample k (k = 1..16) is taken at edge E0 + k·(SETTLE+1).
- `word_valid` is high in the cycle after edge E0 + 16·(SETTLE+1). With SETTLE = 1 that is after E0+32.
- Following words: the first sample is SETTLE+1 edges after the handshake edge. Each word costs 16·(SETTLE+1) + 1 cycles with no stall.
- SET: `select` updates on the strobe edge, i.e. 1-cycle latency.
- `err_cmd` is high for exactly the cycle after the offending strobe.
- Wrap-around: `select` goes 511 -> 0 mid-word without error. `word_base` reports the pre-wrap base.
- ABORT and `word_ready` in the same cycle: ABORT wins. The word is counted as not delivered.
- Asynchronous `reset` mid-scan: all outputs go to 0 immediately, state goes to IDLE, and no word is emitted after release.

## Test plan
- Reset, then SET with parameter 0x00A5: `select` = 0x0A5 one cycle after the strobe; `busy` = 0; no `word_valid`.
- SCAN, param 0x0000 (start 0, N = 1), SETTLE = 1, `q` = `select[0]`, `actual_select` = `select`: one word, `word_data` = 0xAAAA, `word_base` = 0. `word_valid` rises after E0+32. `busy` falls after the handshake; `err_sel` = 0.
- SCAN, param 0x05F8 (start 0x1F8, N = 3), `word_ready` held low 10 cycles on word 2: three words with bases 0x1F8, 0x008, 0x018. Data stays stable during the stall. `select` wraps with no error.
- SCAN N = 4, ABORT strobe during PUSH of word 2 while `word_ready` = 1: word 2 is not counted; state goes to IDLE the next cycle; `word_valid` = 0; no further words.
- During a scan, SET and code 0x7F: each gives a one-cycle `err_cmd` pulse; the scan completes unchanged. Forcing `actual_select` != `select` at one sample sets `err_sel`, which stays set until the next SCAN.
- Assert `reset` mid-SETTLE: all outputs 0 asynchronously; after release, a new SCAN runs normally.
